// File: rtl/axi_memory_globals_pkg.sv
// Shared state, burst and response types for the AXI memory model read/write slaves.
package axi_memory_globals_pkg;

  typedef enum logic [1:0] {
    aridle,
    arstart,
    arreadys
  } arstate_type;

  typedef enum logic [2:0] {
    ridle,
    rstart,
    rwait,
    rvalids,
    rerror
  } rstate_type;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_type;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_memory_burst_addr_gen.sv
// Combinational next-beat address (FIXED/INCR/WRAP) and per-beat error detection.
module axi_memory_burst_addr_gen
  import axi_memory_globals_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 128
) (
  input  logic [ADDR_WIDTH-1:0] cur_addr,
  input  logic [2:0]            arsize,
  input  logic [7:0]            arlen,
  input  logic [1:0]            arburst,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  beat_err
);

  localparam int unsigned NB_LOG2 = $clog2(DATA_WIDTH / 8);

  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] total;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] incr;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  wrap_len_ok;
  logic                  burst_err;

  always_comb begin
    step        = ADDR_WIDTH'(1) << arsize;
    total       = (ADDR_WIDTH'(arlen) + ADDR_WIDTH'(1)) << arsize;
    base        = cur_addr & ~(total - ADDR_WIDTH'(1));
    incr        = cur_addr + step;
    word_idx    = cur_addr >> NB_LOG2;
    wrap_len_ok = arlen inside {8'd1, 8'd3, 8'd7, 8'd15};
    // Burst-level faults poison every beat; range faults only the beats past the end.
    burst_err   = (arburst == BURST_RSVD) || (arsize > 3'(NB_LOG2)) ||
                  ((arburst == BURST_WRAP) && !wrap_len_ok);
    beat_err    = burst_err || (word_idx >= ADDR_WIDTH'(MEM_DEPTH));

    next_addr = cur_addr;
    case (burst_type'(arburst))
      BURST_INCR: next_addr = incr;
      BURST_WRAP: next_addr = (incr == base + total) ? base : incr;
      default:    next_addr = cur_addr;
    endcase
  end

endmodule

// File: rtl/axi_memory_read_slave.sv
// AXI4 read-path slave: one burst at a time, 1-cycle-latency memory port, OKAY/SLVERR beats.
module axi_memory_read_slave
  import axi_memory_globals_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 128
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ID_WIDTH-1:0]          arid,
  input  logic [ADDR_WIDTH-1:0]        araddr,
  input  logic [7:0]                   arlen,
  input  logic [2:0]                   arsize,
  input  logic [1:0]                   arburst,
  input  logic                         arvalid,
  output logic                         arready,
  output logic [ID_WIDTH-1:0]          rid,
  output logic [DATA_WIDTH-1:0]        rdata,
  output logic [1:0]                   rresp,
  output logic                         rlast,
  output logic                         rvalid,
  input  logic                         rready,
  output logic                         mem_rd_en,
  output logic [$clog2(MEM_DEPTH)-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]        mem_rd_data
);

  localparam int unsigned NB_LOG2 = $clog2(DATA_WIDTH / 8);
  localparam int unsigned MAW     = $clog2(MEM_DEPTH);

  arstate_type           ar_state;
  rstate_type            r_state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [7:0]            len_q;
  logic [7:0]            beat_cnt;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic                  beat_err;

  axi_memory_burst_addr_gen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_addr_gen (
    .cur_addr (cur_addr),
    .arsize   (size_q),
    .arlen    (len_q),
    .arburst  (burst_q),
    .next_addr(next_addr),
    .beat_err (beat_err)
  );

  // Decoded from registered state so the read lands in rwait, one cycle after rstart.
  assign mem_rd_en   = (r_state == rstart) && !beat_err;
  assign mem_rd_addr = mem_rd_en ? cur_addr[NB_LOG2 +: MAW] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      ar_state <= aridle;
      r_state  <= ridle;
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rlast    <= 1'b0;
      rdata    <= '0;
      rresp    <= '0;
      rid      <= '0;
      cur_addr <= '0;
      beat_cnt <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
    end else begin
      case (ar_state)
        aridle: begin
          if (arvalid && (r_state == ridle)) begin
            ar_state <= arstart;
            arready  <= 1'b1;
          end
        end
        arstart: begin
          if (arvalid) begin
            rid      <= arid;
            len_q    <= arlen;
            size_q   <= arsize;
            burst_q  <= arburst;
            arready  <= 1'b0;
            ar_state <= arreadys;
          end
        end
        arreadys: begin
          if (rvalid && rready && rlast) ar_state <= aridle;
        end
        default: ar_state <= aridle;
      endcase

      case (r_state)
        ridle: begin
          if ((ar_state == arstart) && arvalid) begin
            cur_addr <= araddr;
            beat_cnt <= '0;
            r_state  <= rstart;
          end
        end
        rstart: begin
          if (beat_err) begin
            rvalid  <= 1'b1;
            rdata   <= '0;
            rresp   <= RESP_SLVERR;
            rlast   <= (beat_cnt == len_q);
            r_state <= rerror;
          end else begin
            r_state <= rwait;
          end
        end
        rwait: begin
          rdata   <= mem_rd_data;
          rvalid  <= 1'b1;
          rresp   <= RESP_OKAY;
          rlast   <= (beat_cnt == len_q);
          r_state <= rvalids;
        end
        rvalids, rerror: begin
          if (rready) begin
            rvalid <= 1'b0;
            rlast  <= 1'b0;
            if (rlast) begin
              r_state <= ridle;
            end else begin
              cur_addr <= next_addr;
              beat_cnt <= beat_cnt + 8'd1;
              r_state  <= rstart;
            end
          end
        end
        default: r_state <= ridle;
      endcase
    end
  end

endmodule
